// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the data-bus access controller:
// access size, controller state, dbus request/response and strobe helpers.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Byte-lane strobe for a store of the given size at byte offset off.
    function automatic logic [7:0] size_strobe(input msize_t size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            MSIZE1:  base = 8'h01;
            MSIZE2:  base = 8'h03;
            MSIZE4:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Bit shift amount for a byte offset within the 64-bit lane.
    function automatic logic [5:0] byte_shift(input logic [2:0] off);
        return {off, 3'b000};
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input msize_t size, input logic [2:0] off);
        logic bad;
        case (size)
            MSIZE1:  bad = 1'b0;
            MSIZE2:  bad = off[0];
            MSIZE4:  bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load data alignment: shift the selected bytes down to bit 0 and
// sign- or zero-extend them to the full 64-bit width.
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  msize_t      size,
    input  logic        uns,
    output logic [63:0] result
);

    logic [63:0] shifted;

    // Align then extend according to access size and signedness.
    always_comb begin
        shifted = data >> byte_shift(offset);
        result  = shifted;
        case (size)
            MSIZE1:  result = {{56{~uns & shifted[7]}},  shifted[7:0]};
            MSIZE2:  result = {{48{~uns & shifted[15]}}, shifted[15:0]};
            MSIZE4:  result = {{32{~uns & shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-bus access controller: accepts one load/store per memory
// instruction, holds the dbus request until the handshake completes,
// stalls upstream while outstanding and returns extended load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_store,
    input  msize_t          req_size,
    input  logic            req_uns,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            misalign
);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic        accept;
    logic        bad;
    logic        capture;
    logic        lat_store;
    logic        lat_uns;
    logic [2:0]  lat_off;
    logic [63:0] ext_data;

    load_extend u_load_extend (
        .data   (dresp.data),
        .offset (lat_off),
        .size   (dreq.size),
        .uns    (lat_uns),
        .result (ext_data)
    );

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, acceptance/capture strobes and pipeline stall.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        bad     = is_misaligned(req_size, req_addr[2:0]);
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = bad ? DONE : REQ;
                end
            end
            REQ: begin
                if (dresp.addr_ok) begin
                    capture = dresp.data_ok;
                    state_d = dresp.data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dresp.data_ok) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        stall = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == WAIT);
    end

    // Registered bus request, latched request fields and result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dreq      <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            misalign  <= 1'b0;
            lat_store <= 1'b0;
            lat_uns   <= 1'b0;
            lat_off   <= '0;
        end else begin
            done <= (state_d == DONE);
            if (accept) begin
                lat_store   <= req_store;
                lat_uns     <= req_uns;
                lat_off     <= req_addr[2:0];
                rdata       <= '0;
                misalign    <= bad;
                dreq.valid  <= ~bad;
                dreq.addr   <= {req_addr[63:3], 3'b000};
                dreq.size   <= req_size;
                dreq.strobe <= req_store ? size_strobe(req_size, req_addr[2:0]) : '0;
                dreq.data   <= req_store ? (req_wdata << byte_shift(req_addr[2:0])) : '0;
            end
            // Address phase ends once the bus accepts it.
            if ((state_q == REQ) && dresp.addr_ok) begin
                dreq.valid <= 1'b0;
            end
            if (capture) begin
                rdata <= lat_store ? '0 : ext_data;
            end
            if (state_q == DONE) begin
                misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    msize_t      req_size;
    logic        req_uns;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic        misalign;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mis;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_store (req_store),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .dreq      (dreq),
        .dresp     (dresp),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .misalign  (misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = 1'b0;
        req_store = 1'b0;
        req_size  = MSIZE1;
        req_uns   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dresp     = '0;
    endtask

    task automatic drive_req(input logic st, input int sz, input logic un,
                             input logic [63:0] addr, input logic [63:0] wd);
        req_valid = 1'b1;
        req_store = st;
        req_size  = msize_t'(sz);
        req_uns   = un;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] bus, input int a,
                                               input int sz, input logic un);
        logic [63:0] v;
        int n;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = bus[8*(a+i) +: 8];
        if (!un && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_strobe(input int a, input int sz);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < (1 << sz); i++) s[a+i] = 1'b1;
        return s;
    endfunction

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        tick();
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
        tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign got %0b want 0", misalign); end
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
        tests++; if (dreq !== '0) begin fails++; $display("FAIL reset_dreq got %h want 0", dreq); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", stall); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_store_d();
        exp_t e;
        drive_req(1'b1, 3, 1'b0, 64'h0000_0000_8000_0010, 64'h1122334455667788);
        exp_q.push_back('{mis: 1'b0, data: 64'h0});
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sd_stall_c0 got %0b want 1", stall); end
        tick();
        req_valid = 1'b0; req_addr = 64'hDEAD_BEEF_0000_0005; req_wdata = '1; req_size = MSIZE1;
        tests++; if (dreq.valid !== 1'b1) begin fails++; $display("FAIL sd_valid got %0b want 1", dreq.valid); end
        tests++; if (dreq.strobe !== 8'hFF) begin fails++; $display("FAIL sd_strobe got %h want ff", dreq.strobe); end
        tests++; if (dreq.addr !== 64'h8000_0010) begin fails++; $display("FAIL sd_addr got %h want 80000010", dreq.addr); end
        tests++; if (dreq.data !== 64'h1122334455667788) begin fails++; $display("FAIL sd_data got %h want 1122334455667788", dreq.data); end
        dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 64'hFFFF_0000_FFFF_0000;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sd_stall_c1 got %0b want 1", stall); end
        tick();
        dresp = '0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL sd_done_c2 got %0b want 1", done); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sd_stall_c2 got %0b want 0", stall); end
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL sd_scoreboard got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            if (rdata !== e.data || misalign !== e.mis) begin
                fails++; $display("FAIL sd_result got %h/%0b want %h/%0b", rdata, misalign, e.data, e.mis);
            end
        end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL sd_done_c3 got %0b want 0", done); end
    endtask

    task automatic test_store_b();
        drive_req(1'b1, 0, 1'b0, 64'h0000_0000_8000_0013, 64'h0000_0000_0000_00AB);
        tick();
        req_valid = 1'b0;
        tests++; if (dreq.strobe !== 8'h08) begin fails++; $display("FAIL sb_strobe got %h want 08", dreq.strobe); end
        tests++; if (dreq.data[31:24] !== 8'hAB) begin fails++; $display("FAIL sb_data got %h want ab", dreq.data[31:24]); end
        tests++; if (dreq.addr !== 64'h8000_0010) begin fails++; $display("FAIL sb_addr got %h want 80000010", dreq.addr); end
        dresp.addr_ok = 1'b1;
        tick();
        dresp.addr_ok = 1'b0;
        tests++; if (dreq.valid !== 1'b0) begin fails++; $display("FAIL sb_valid_wait got %0b want 0", dreq.valid); end
        dresp.data_ok = 1'b1;
        tick();
        dresp = '0;
        tests++; if (done !== 1'b1 || rdata !== 64'h0) begin fails++; $display("FAIL sb_done got %0b/%h want 1/0", done, rdata); end
        tick();
    endtask

    task automatic test_load_half(input logic un);
        exp_t e;
        logic [63:0] bus;
        bus = 64'h8001_0000_0000_0000;
        drive_req(1'b0, 1, un, 64'h0000_0000_8000_0006, 64'h5555_5555_5555_5555);
        exp_q.push_back('{mis: 1'b0, data: model_load(bus, 6, 1, un)});
        tick();
        req_valid = 1'b0; req_uns = ~un; req_addr = '0;
        tests++; if (dreq.valid !== 1'b1 || dreq.strobe !== 8'h00 || dreq.data !== 64'h0) begin
            fails++; $display("FAIL lh_req got v=%0b s=%h d=%h want 1/00/0", dreq.valid, dreq.strobe, dreq.data); end
        tick();
        tests++; if (dreq.valid !== 1'b1) begin fails++; $display("FAIL lh_valid_c2 got %0b want 1", dreq.valid); end
        dresp.addr_ok = 1'b1;
        tick();
        dresp.addr_ok = 1'b0;
        tests++; if (dreq.valid !== 1'b0) begin fails++; $display("FAIL lh_valid_c3 got %0b want 0", dreq.valid); end
        tick();
        tests++; if (dreq.valid !== 1'b0 || stall !== 1'b1) begin
            fails++; $display("FAIL lh_c4 got v=%0b stall=%0b want 0/1", dreq.valid, stall); end
        tick();
        dresp.data_ok = 1'b1; dresp.data = bus;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL lh_early_done got %0b want 0", done); end
        tick();
        dresp = '0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL lh_done_c6 got %0b want 1", done); end
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL lh_scoreboard got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            if (rdata !== e.data || misalign !== e.mis) begin
                fails++; $display("FAIL lh_rdata uns=%0b got %h want %h", un, rdata, e.data);
            end
        end
        tick();
    endtask

    task automatic test_misalign();
        exp_t e;
        drive_req(1'b0, 2, 1'b0, 64'h0000_0000_8000_0002, 64'h0);
        exp_q.push_back('{mis: 1'b1, data: 64'h0});
        dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 64'h1234_5678_9ABC_DEF0;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ma_stall_c0 got %0b want 1", stall); end
        tick();
        req_valid = 1'b0;
        tests++; if (done !== 1'b1 || dreq.valid !== 1'b0) begin
            fails++; $display("FAIL ma_done got done=%0b valid=%0b want 1/0", done, dreq.valid); end
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL ma_scoreboard got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            if (misalign !== e.mis || rdata !== e.data) begin
                fails++; $display("FAIL ma_result got %0b/%h want %0b/%h", misalign, rdata, e.mis, e.data);
            end
        end
        tick();
        dresp = '0;
        tests++; if (done !== 1'b0 || misalign !== 1'b0 || dreq.valid !== 1'b0) begin
            fails++; $display("FAIL ma_after got d=%0b m=%0b v=%0b want 0/0/0", done, misalign, dreq.valid); end
    endtask

    task automatic test_reset_mid_access();
        drive_req(1'b0, 3, 1'b0, 64'h0000_0000_8000_0008, 64'h0);
        tick();
        req_valid = 1'b0;
        dresp.addr_ok = 1'b1;
        tick();
        dresp.addr_ok = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        dresp.data_ok = 1'b1; dresp.data = 64'hCAFE_F00D_CAFE_F00D;
        tests++; if (stall !== 1'b0 || done !== 1'b0 || dreq.valid !== 1'b0) begin
            fails++; $display("FAIL rm_after_reset got s=%0b d=%0b v=%0b want 0/0/0", stall, done, dreq.valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            dresp = '0;
            tests++; if (done !== 1'b0 || stall !== 1'b0) begin
                fails++; $display("FAIL rm_no_done c%0d got d=%0b s=%0b want 0/0", i, done, stall); end
        end
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL rm_rdata got %h want 0", rdata); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic        st, un, mis, got;
        int          sz, a, aok, dok, c, exp_c;
        logic [63:0] addr, wd, bus;
        for (int k = 0; k < 16; k++) begin
            st   = 1'($urandom_range(0, 1));
            un   = 1'($urandom_range(0, 1));
            sz   = $urandom_range(0, 3);
            a    = $urandom_range(0, 7) & ~((1 << sz) - 1);
            if ((k % 4) == 3 && sz != 0) a = a | 1;
            mis  = (a % (1 << sz)) != 0;
            addr = {$urandom, $urandom};
            addr[2:0] = 3'(a);
            wd   = {$urandom, $urandom};
            bus  = {$urandom, $urandom};
            aok  = $urandom_range(0, 3);
            dok  = $urandom_range(0, 3);
            exp_c = mis ? 1 : 2 + aok + dok;
            drive_req(st, sz, un, addr, wd);
            exp_q.push_back('{mis: mis, data: (mis || st) ? 64'h0 : model_load(bus, a, sz, un)});
            tick();
            c = 1;
            got = 1'b0;
            while (!got && c <= 20) begin
                if (done === 1'b1) begin
                    got = 1'b1;
                    dresp = '0;
                    tests++; if (c != exp_c) begin fails++; $display("FAIL b2b_latency k=%0d got %0d want %0d", k, c, exp_c); end
                    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall_done k=%0d got %0b want 0", k, stall); end
                    tests++;
                    if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_scoreboard k=%0d got empty want entry", k); end
                    else begin
                        e = exp_q.pop_front();
                        if (rdata !== e.data || misalign !== e.mis) begin
                            fails++; $display("FAIL b2b_result k=%0d got %h/%0b want %h/%0b", k, rdata, misalign, e.data, e.mis);
                        end
                    end
                end else begin
                    dresp = '0;
                    dresp.data = {$urandom, $urandom};
                    if (!mis && c == 1 + aok) begin
                        tests++;
                        if ({dreq.valid, dreq.addr, dreq.strobe, dreq.data} !==
                            {1'b1, addr[63:3], 3'b000, st ? model_strobe(a, sz) : 8'h00, st ? (wd << (8 * a)) : 64'h0}) begin
                            fails++; $display("FAIL b2b_dreq k=%0d got v=%0b a=%h s=%h d=%h", k, dreq.valid, dreq.addr, dreq.strobe, dreq.data);
                        end
                        dresp.addr_ok = 1'b1;
                    end
                    if (!mis && c == 1 + aok + dok) begin
                        dresp.data_ok = 1'b1;
                        dresp.data = bus;
                    end
                    req_addr  = {$urandom, $urandom};
                    req_wdata = {$urandom, $urandom};
                    req_size  = msize_t'($urandom_range(0, 3));
                    req_uns   = ~un;
                    req_store = ~st;
                    tick();
                    c++;
                end
            end
            if (!got) begin
                tests++; fails++; $display("FAIL b2b_timeout k=%0d got no done want done", k);
                set_idle();
                tick();
            end
            tick();
        end
        set_idle();
        tick();
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        reset = 1'b0;
        tick();
        test_reset();
        test_store_d();
        test_store_b();
        test_load_half(1'b0);
        test_load_half(1'b1);
        test_misalign();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
